return_address_stack: RTL and testbench
=======================================

// Module: return_address_stack
// PURPOSE
//  LIFO of return addresses for JAL/CALL and return. The branch/decode control
//  pushes PC+4 when a link jump is taken and pops when the stop/return bit is
//  set. ReturnAddress drives the PC unit's return source (PC_Src_Ra). It must be
//  valid combinationally before the clock edge at which the PC loads it.
// PARAMETERS
//  DEPTH       8   number of 32-bit entries (power of two not required, >=2)
//  ADDR_WIDTH  32  width of stored addresses
//  CNT_WIDTH   $clog2(DEPTH+1)  derived localparam; width of Count
// PORTS
//  clock          in   1           rising-edge clock
//  reset          in   1           asynchronous, active-high reset
//  sig_push       in   1           push PushAddress this cycle
//  sig_pop        in   1           pop top entry this cycle
//  sig_clear_err  in   1           synchronous clear of sticky error flags
//  PushAddress    in   ADDR_WIDTH  link address to push (PC+4)
//  ReturnAddress  out  ADDR_WIDTH  current top entry; 0 when empty
//  Count          out  CNT_WIDTH   number of valid entries
//  Empty          out  1           Count==0
//  Full           out  1           Count==DEPTH
//  Overflow       out  1           sticky: push dropped while full
//  Underflow      out  1           sticky: pop requested while empty
// BEHAVIOUR
//  - Reset (async): sp=0, Overflow=Underflow=0. Storage is not cleared. Outputs
//    read ReturnAddress=0, Count=0, Empty=1, Full=0.
//  - sp is the count and points at the next free slot. Top = mem[sp-1].
//  - ReturnAddress is combinational from the registered sp and storage. It is 0
//    when Empty. There is no pop-to-data latency, so the consumer samples the
//    popped value on the same edge that the pop is applied.
//  - Update at posedge clock, evaluated in this priority:
//    push only, not Full     : mem[sp]<=PushAddress; sp<=sp+1
//    push only, Full         : write dropped; sp held; Overflow<=1
//    pop only, not Empty     : sp<=sp-1 (the entry is left stale)
//    pop only, Empty         : sp held; Underflow<=1
//    push+pop, not Empty     : mem[sp-1]<=PushAddress; sp held (replace top,
//                              legal even when Full; no Overflow)
//    push+pop, Empty         : treated as push; Underflow<=1
//    neither                 : hold
//  - sig_clear_err clears both sticky flags on the next edge. A new error
//    detected on that same edge wins, and its flag ends up set.
//  - Empty/Full/Count are decoded combinationally from sp. No wrap-around:
//    sp is saturated to the range 0..DEPTH.
//  - Reset asserted mid-operation aborts any push/pop in flight. After reset,
//    the first push lands in mem[0].
//  - Writes are single-port. Read is asynchronous (a register array, not a
//    block RAM).
// STRUCTURE
//  - Shared package/header: ADDR_WIDTH default (32), plus the PC source codes
//    PC_Src_Dft/Ra/BTA/Jmp that the control unit uses to qualify sig_pop with
//    PC_Src_Ra.
//  - One sub-module, ras_storage: DEPTH x ADDR_WIDTH register file with one
//    write port (we, waddr, wdata) and one async read port. The pointer,
//    flags and priority logic stay in the top module.
// TESTING
//  1 Reset, then push 0x04, 0x08, 0x0C -> Count=3, ReturnAddress=0x0C; pop ->
//    ReturnAddress=0x08 after the edge, Count=2.
//  2 Push 0x100+4*i for i=0..7 (DEPTH=8) -> Full=1. Push 0xDEAD -> Overflow=1,
//    Count=8, top still 0x11C. Pop 8 times -> values 0x11C..0x100, then Empty.
//  3 Pop on empty -> Underflow=1, Count=0, ReturnAddress=0. Pulse
//    sig_clear_err -> Underflow=0 next cycle.
//  4 Count=2 with top 0x20, push+pop with PushAddress=0x44 -> Count=2,
//    ReturnAddress=0x44. Repeat the same operation while Full -> no Overflow.
//  5 Assert reset asynchronously mid-cycle with Count=5 -> Count=0 and Empty=1
//    immediately, before the next edge. Then push 0x50 -> Count=1,
//    ReturnAddress=0x50.
//  6 Push+pop on empty with 0x60 -> Count=1, ReturnAddress=0x60, Underflow=1.
//    Assert sig_clear_err on the same edge as a new underflow -> Underflow=1.

Source files
------------

// File: rtl/return_address_stack_pkg.sv
// Shared definitions for the return address stack and its users.
// Holds the default address width and the PC source select codes.
package return_address_stack_pkg;

  localparam int DEF_ADDR_WIDTH = 32;

  // PC unit source select; control qualifies
  // sig_pop with PC_Src_Ra.
  typedef enum logic [1:0] {
    PC_Src_Dft = 2'd0,
    PC_Src_Ra  = 2'd1,
    PC_Src_BTA = 2'd2,
    PC_Src_Jmp = 2'd3
  } pc_src_e;

endpackage

// File: rtl/return_address_stack_ras_storage.sv
// ras_storage: DEPTH x ADDR_WIDTH register file.
// Ports: i_clk, write port (i_we, i_waddr, i_wdata), async read (i_raddr -> o_rdata).
module ras_storage #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [ADDR_WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [ADDR_WIDTH-1:0] o_rdata
);

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we && (int'(i_waddr) < DEPTH)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_address_stack.sv
// Return address stack: LIFO of link addresses for call/return prediction.
// Ports: clock, reset (async high), sig_push/sig_pop/sig_clear_err,
// PushAddress in; ReturnAddress, Count, Empty, Full, Overflow, Underflow out.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter  int DEPTH      = 8,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sig_push,
  input  logic                  sig_pop,
  input  logic                  sig_clear_err,
  input  logic [ADDR_WIDTH-1:0] PushAddress,
  output logic [ADDR_WIDTH-1:0] ReturnAddress,
  output logic [CNT_WIDTH-1:0]  Count,
  output logic                  Empty,
  output logic                  Full,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] LP_FULL = CNT_WIDTH'(DEPTH);

  logic [CNT_WIDTH-1:0]  r_sp;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_both;
  logic                  w_push_only;
  logic                  w_pop_only;
  logic                  w_we;
  logic [IDX_W-1:0]      w_top_idx;
  logic [IDX_W-1:0]      w_waddr;
  logic [ADDR_WIDTH-1:0] w_rdata;

  assign w_empty     = (r_sp == '0);
  assign w_full      = (r_sp == LP_FULL);
  assign w_both      = sig_push & sig_pop;
  assign w_push_only = sig_push & ~sig_pop;
  assign w_pop_only  = sig_pop & ~sig_push;
  assign w_top_idx   = IDX_W'(r_sp - 1'b1);

  // Push+pop on a non-empty stack replaces the top
  // in place; otherwise a push writes the free slot.
  assign w_we    = w_both | (w_push_only & ~w_full);
  assign w_waddr = (w_both & ~w_empty) ? w_top_idx
                                       : IDX_W'(r_sp);

  ras_storage #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_storage (
    .i_clk   (clock),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (PushAddress),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      // Clear first so an error on the same
      // edge overrides it below.
      if (sig_clear_err) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      unique case (1'b1)
        w_both: begin
          if (w_empty) begin
            r_sp  <= r_sp + 1'b1;
            r_unf <= 1'b1;
          end
        end
        w_push_only: begin
          if (w_full) r_ovf <= 1'b1;
          else        r_sp  <= r_sp + 1'b1;
        end
        w_pop_only: begin
          if (w_empty) r_unf <= 1'b1;
          else         r_sp  <= r_sp - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ReturnAddress = w_empty ? '0 : w_rdata;
  assign Count         = r_sp;
  assign Empty         = w_empty;
  assign Full          = w_full;
  assign Overflow      = r_ovf;
  assign Underflow     = r_unf;

endmodule

// File: tb/tb_return_address_stack.sv
// Testbench for return_address_stack.
// Directed scenarios plus random traffic against a queue model.
module tb_return_address_stack;
  import return_address_stack_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          sig_push;
  logic          sig_pop;
  logic          sig_clear_err;
  logic [AW-1:0] PushAddress;
  logic [AW-1:0] ReturnAddress;
  logic [CW-1:0] Count;
  logic          Empty;
  logic          Full;
  logic          Overflow;
  logic          Underflow;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] m_q[$];
  bit            m_ovf;
  bit            m_unf;

  always #5 clock = ~clock;

  return_address_stack #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .sig_push      (sig_push),
    .sig_pop       (sig_pop),
    .sig_clear_err (sig_clear_err),
    .PushAddress   (PushAddress),
    .ReturnAddress (ReturnAddress),
    .Count         (Count),
    .Empty         (Empty),
    .Full          (Full),
    .Overflow      (Overflow),
    .Underflow     (Underflow)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [31:0] top;
    n   = m_q.size();
    top = (n > 0) ? m_q[n-1] : 32'h0;
    check({tag, ".ra"},  ReturnAddress, top);
    check({tag, ".cnt"}, 32'(Count), 32'(n));
    check({tag, ".emp"}, 32'(Empty), 32'(n == 0));
    check({tag, ".ful"}, 32'(Full), 32'(n == DEPTH));
    check({tag, ".ovf"}, 32'(Overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(Underflow), 32'(m_unf));
  endtask

  // Reference: stack semantics on a queue.
  task automatic model(input bit push, input bit pop,
                       input bit clr, input logic [31:0] a);
    bit eo;
    bit eu;
    int n;
    eo = 0;
    eu = 0;
    n  = m_q.size();
    if (push && pop) begin
      if (n == 0) begin
        m_q.push_back(a);
        eu = 1;
      end else begin
        m_q[n-1] = a;
      end
    end else if (push) begin
      if (n == DEPTH) eo = 1;
      else m_q.push_back(a);
    end else if (pop) begin
      if (n == 0) eu = 1;
      else void'(m_q.pop_back());
    end
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    m_ovf = m_ovf | eo;
    m_unf = m_unf | eu;
  endtask

  task automatic step(input string tag,
                      input bit push, input bit pop,
                      input bit clr,
                      input logic [31:0] a);
    sig_push      = push;
    sig_pop       = pop;
    sig_clear_err = clr;
    PushAddress   = a;
    @(posedge clock);
    model(push, pop, clr, a);
    #1;
    check_all(tag);
  endtask

  // Async reset pulse in the middle of a cycle.
  task automatic pulse_reset(input string tag);
    sig_push      = 1'b0;
    sig_pop       = 1'b0;
    sig_clear_err = 1'b0;
    #1;
    reset = 1'b1;
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
    #1;
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    sig_push      = 1'b0;
    sig_pop       = 1'b0;
    sig_clear_err = 1'b0;
    PushAddress   = '0;
    m_ovf         = 0;
    m_unf         = 0;
    #12;
    check_all("rst");
    reset = 1'b0;

    // 1: basic push/pop
    step("t1p0", 1, 0, 0, 32'h04);
    step("t1p1", 1, 0, 0, 32'h08);
    step("t1p2", 1, 0, 0, 32'h0C);
    check("t1.top", ReturnAddress, 32'h0C);
    step("t1pop", 0, 1, 0, 32'h0);
    check("t1.pop", ReturnAddress, 32'h08);

    // 2: fill, overflow, drain
    pulse_reset("t2rst");
    for (int i = 0; i < DEPTH; i++)
      step("t2fill", 1, 0, 0, 32'h100 + 4 * i);
    step("t2ovf", 1, 0, 0, 32'hDEAD);
    check("t2.top", ReturnAddress, 32'h11C);
    check("t2.ovf", 32'(Overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("t2.drain", ReturnAddress,
            32'h11C - 4 * i);
      step("t2pop", 0, 1, 0, 32'h0);
    end
    check("t2.emp", 32'(Empty), 32'd1);

    // 3: underflow then clear
    step("t3unf", 0, 1, 1, 32'h0);
    step("t3unf2", 0, 1, 0, 32'h0);
    check("t3.unf", 32'(Underflow), 32'd1);
    step("t3clr", 0, 0, 1, 32'h0);
    check("t3.clr", 32'(Underflow), 32'd0);

    // 4: replace top, including while full
    pulse_reset("t4rst");
    step("t4a", 1, 0, 0, 32'h10);
    step("t4b", 1, 0, 0, 32'h20);
    step("t4rep", 1, 1, 0, 32'h44);
    check("t4.rep", ReturnAddress, 32'h44);
    for (int i = 0; i < DEPTH - 2; i++)
      step("t4fill", 1, 0, 0, 32'h200 + i);
    step("t4repf", 1, 1, 0, 32'h88);
    check("t4.noovf", 32'(Overflow), 32'd0);

    // 5: async reset with Count=5
    pulse_reset("t5rst0");
    for (int i = 0; i < 5; i++)
      step("t5fill", 1, 0, 0, 32'h300 + i);
    sig_push = 1'b1;
    PushAddress = 32'hBAD;
    #1;
    reset = 1'b1;
    #1;
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
    check("t5.cnt", 32'(Count), 32'd0);
    check("t5.emp", 32'(Empty), 32'd1);
    sig_push = 1'b0;
    reset = 1'b0;
    step("t5push", 1, 0, 0, 32'h50);
    check("t5.ra", ReturnAddress, 32'h50);

    // 6: push+pop on empty; clear vs new error
    pulse_reset("t6rst");
    step("t6pp", 1, 1, 0, 32'h60);
    check("t6.unf", 32'(Underflow), 32'd1);
    step("t6pop", 0, 1, 0, 32'h0);
    step("t6clr", 0, 1, 1, 32'h0);
    check("t6.win", 32'(Underflow), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit p;
      bit q;
      bit c;
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 2)
        pulse_reset("rnd.rst");
      else
        step("rnd", p, q, c, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
